spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data-phase bit count and width of register-side data ports.
REQ-002 Parameter ADDRESS_WIDTH, default 32, address-phase bit count and width of register-side address ports.
REQ-003 Parameter SYNC_STAGES, default 2, flip-flops per synchronizer on SCK, SS and MOSI.
REQ-004 clock  input  1  system clock, single clock domain; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 clock_polarity  input  1  SCK idle level (CPOL); static while SS is high.
REQ-007 clock_phase  input  1  CPHA; 0 = sample on leading edge, 1 = sample on trailing edge; static while SS is high.
REQ-008 SCK  input  1  serial clock from master, asynchronous to clock.
REQ-009 SS  input  1  slave select, active low.
REQ-010 MOSI  input  1  serial data from master, MSB first.
REQ-011 MISO  output  1  serial data to master, MSB first.
REQ-012 wr_valid  output  1  one-cycle pulse: write frame complete.
REQ-013 wr_address  output  ADDRESS_WIDTH  write address, valid with wr_valid.
REQ-014 wr_data  output  DATA_WIDTH  write data, valid with wr_valid.
REQ-015 rd_req  output  1  one-cycle pulse: read data requested.
REQ-016 rd_address  output  ADDRESS_WIDTH  read address, valid with rd_req.
REQ-017 rd_data  input  DATA_WIDTH  read data, sampled exactly one cycle after rd_req.
REQ-018 busy  output  1  high while a frame is in progress (synchronized SS low).
REQ-019 frame_error  output  1  one-cycle pulse: SS deasserted before frame complete.

Function
REQ-020 Frame = ADDRESS_WIDTH address bits then DATA_WIDTH data bits, MSB first; address MSB 1 = write, 0 = read; emitted addresses carry that MSB cleared.
REQ-021 Leading edge = first SCK transition away from clock_polarity level; trailing edge = return to it; edges detected on synchronized SCK.
REQ-022 FSM states IDLE, ADDR, FETCH, DATA, DONE; IDLE->ADDR on synchronized SS fall, bit counter cleared.
REQ-023 ADDR: shift MOSI at each sample edge; after ADDRESS_WIDTH samples go DATA (write) or FETCH (read, rd_req pulsed that cycle).
REQ-024 FETCH: lasts one cycle; loads rd_data into transmit shift register; ->DATA.
REQ-025 MISO drives 0 in IDLE and ADDR; read frame presents rd_data MSB from the first shift edge after the last address sample, next bit on each following shift edge.
REQ-026 Write frame: MISO stays 0; after DATA_WIDTH data samples wr_valid pulses one cycle with wr_address/wr_data; ->DONE.
REQ-027 Read frame: after DATA_WIDTH data samples ->DONE, no further pulses.
REQ-028 DONE: extra SCK edges ignored; ->IDLE on SS rise.
REQ-029 SS rise in ADDR, FETCH or DATA: frame_error pulses, no wr_valid, ->IDLE, MISO to 0.
REQ-030 Supported SCK half-period >= 4 clock cycles; SCK edges while SS high ignored.
REQ-031 Bit counter width $clog2(ADDRESS_WIDTH+DATA_WIDTH+1), no wrap within a frame.

Reset
REQ-032 reset_n low: state IDLE, shift registers and counter 0, MISO, wr_valid, rd_req, busy, frame_error 0, wr_address/wr_data 0, synchronizers to SS=1, SCK=clock_polarity.
REQ-033 Reset mid-frame aborts without frame_error; first frame after release begins at the next SS fall.

Structure
REQ-034 Shared package spi_pkg holds FSM state encoding and default width constants, also used by spi_master.
REQ-035 One sub-module spi_sync_edge (synchronizer plus rise/fall detect), instantiated for SCK and SS.

Verification
REQ-036 Mode 0, write, address 0x80000010, data 0xA5A5A5A5 -> one wr_valid, wr_address 0x00000010, wr_data 0xA5A5A5A5, MISO all 0.
REQ-037 Mode 0, read, address 0x00000020, rd_data 0x5A5A1234 -> one rd_req with rd_address 0x00000020, MISO returns 0x5A5A1234.
REQ-038 Mode 3, write 0x80000004/0x12345678, then read same address -> wr_data 0x12345678; read returns supplied rd_data.
REQ-039 SS rise after 10 address bits -> frame_error one pulse, no wr_valid/rd_req; next full frame correct.
REQ-040 reset_n low during data phase -> all outputs 0 asynchronously, no frame_error; next write frame correct.
REQ-041 Mode 1, 2 extra SCK cycles after 64 bits before SS rise -> exactly one wr_valid, no frame_error.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared SPI FSM state encoding and default width constants.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int c_DATA_WIDTH    = 32;
    localparam int c_ADDRESS_WIDTH = 32;
    localparam int c_SYNC_STAGES   = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_FETCH = 3'd2,
        ST_DATA  = 3'd3,
        ST_DONE  = 3'd4
    } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : spi_sync_edge
// Description : Multi-flop synchronizer with rise/fall detection.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter bit RESET_VALUE = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= {SYNC_STAGES{RESET_VALUE}};
            r_prev <= RESET_VALUE;
        end else begin
            r_sync[0] <= async_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign level = r_sync[SYNC_STAGES-1];
    assign rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave
// Description : SPI slave bridging address/data frames to a register port.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH    = c_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = c_ADDRESS_WIDTH,
    parameter int SYNC_STAGES   = c_SYNC_STAGES
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     clock_polarity,
    input  logic                     clock_phase,
    input  logic                     SCK,
    input  logic                     SS,
    input  logic                     MOSI,
    output logic                     MISO,
    output logic                     wr_valid,
    output logic [ADDRESS_WIDTH-1:0] wr_address,
    output logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     rd_req,
    output logic [ADDRESS_WIDTH-1:0] rd_address,
    input  logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     busy,
    output logic                     frame_error
);

    localparam int c_CNT_W = $clog2(ADDRESS_WIDTH + DATA_WIDTH + 1);
    localparam int c_ARM_W = $clog2(SYNC_STAGES + 2);
    localparam logic [c_CNT_W-1:0] c_ADDR_LAST  = c_CNT_W'(ADDRESS_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_FRAME_LAST = c_CNT_W'(ADDRESS_WIDTH + DATA_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [c_ARM_W-1:0] c_ARM_DONE   = c_ARM_W'(SYNC_STAGES + 1);
    localparam logic [c_ARM_W-1:0] c_ARM_ONE    = c_ARM_W'(1);

    spi_state_t               r_state;
    logic [c_CNT_W-1:0]       r_bit_cnt;
    logic [c_ARM_W-1:0]       r_arm_cnt;
    logic [ADDRESS_WIDTH-1:0] r_addr_shift;
    logic [DATA_WIDTH-1:0]    r_data_shift;
    logic [DATA_WIDTH-1:0]    r_tx_shift;
    logic [SYNC_STAGES-1:0]   r_mosi_sync;
    logic                     r_miso;
    logic                     r_wr_valid;
    logic [ADDRESS_WIDTH-1:0] r_wr_address;
    logic [DATA_WIDTH-1:0]    r_wr_data;
    logic                     r_rd_req;
    logic [ADDRESS_WIDTH-1:0] r_rd_address;
    logic                     r_busy;
    logic                     r_frame_error;

    logic w_sck_level, w_lead, w_trail;
    logic w_ss_level, w_ss_rise, w_ss_fall;
    logic w_sample, w_shift, w_mosi, w_armed;
    logic [ADDRESS_WIDTH-1:0] w_addr_next;
    logic [DATA_WIDTH-1:0]    w_data_next;

    // SCK is normalised against CPOL so a rise is always the leading edge.
    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VALUE (1'b0)
    ) u_sync_sck (
        .clock    (clock),
        .reset_n  (reset_n),
        .async_in (SCK ^ clock_polarity),
        .level    (w_sck_level),
        .rise     (w_lead),
        .fall     (w_trail)
    );

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VALUE (1'b1)
    ) u_sync_ss (
        .clock    (clock),
        .reset_n  (reset_n),
        .async_in (SS),
        .level    (w_ss_level),
        .rise     (w_ss_rise),
        .fall     (w_ss_fall)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync[0] <= MOSI;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_mosi_sync[i] <= r_mosi_sync[i-1];
            end
        end
    end

    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sample    = clock_phase ? w_trail : w_lead;
    assign w_shift     = clock_phase ? w_lead  : w_trail;
    // A fall seen while the SS synchronizer is still filling after reset
    // belongs to a frame already in progress and must not start a new one.
    assign w_armed     = (r_arm_cnt == c_ARM_DONE) && !w_ss_level && !w_sck_level ? 1'b1
                       : (r_arm_cnt == c_ARM_DONE);
    assign w_addr_next = {r_addr_shift[ADDRESS_WIDTH-2:0], w_mosi};
    assign w_data_next = {r_data_shift[DATA_WIDTH-2:0], w_mosi};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_bit_cnt     <= '0;
            r_arm_cnt     <= '0;
            r_addr_shift  <= '0;
            r_data_shift  <= '0;
            r_tx_shift    <= '0;
            r_miso        <= 1'b0;
            r_wr_valid    <= 1'b0;
            r_wr_address  <= '0;
            r_wr_data     <= '0;
            r_rd_req      <= 1'b0;
            r_rd_address  <= '0;
            r_busy        <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_wr_valid    <= 1'b0;
            r_rd_req      <= 1'b0;
            r_frame_error <= 1'b0;
            if (r_arm_cnt != c_ARM_DONE) begin
                r_arm_cnt <= r_arm_cnt + c_ARM_ONE;
            end

            case (r_state)
                ST_IDLE: begin
                    r_miso <= 1'b0;
                    if (w_ss_fall && w_armed) begin
                        r_state      <= ST_ADDR;
                        r_bit_cnt    <= '0;
                        r_addr_shift <= '0;
                        r_data_shift <= '0;
                        r_busy       <= 1'b1;
                    end
                end

                ST_ADDR: begin
                    if (w_ss_rise) begin
                        r_state       <= ST_IDLE;
                        r_frame_error <= 1'b1;
                        r_busy        <= 1'b0;
                        r_miso        <= 1'b0;
                    end else if (w_sample) begin
                        r_addr_shift <= w_addr_next;
                        r_bit_cnt    <= r_bit_cnt + c_CNT_ONE;
                        if (r_bit_cnt == c_ADDR_LAST) begin
                            if (w_addr_next[ADDRESS_WIDTH-1]) begin
                                r_state <= ST_DATA;
                            end else begin
                                r_state      <= ST_FETCH;
                                r_rd_req     <= 1'b1;
                                r_rd_address <= {1'b0, w_addr_next[ADDRESS_WIDTH-2:0]};
                            end
                        end
                    end
                end

                ST_FETCH: begin
                    if (w_ss_rise) begin
                        r_state       <= ST_IDLE;
                        r_frame_error <= 1'b1;
                        r_busy        <= 1'b0;
                        r_miso        <= 1'b0;
                    end else begin
                        r_tx_shift <= rd_data;
                        r_state    <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (w_ss_rise) begin
                        r_state       <= ST_IDLE;
                        r_frame_error <= 1'b1;
                        r_busy        <= 1'b0;
                        r_miso        <= 1'b0;
                    end else begin
                        if (w_shift && !r_addr_shift[ADDRESS_WIDTH-1]) begin
                            r_miso     <= r_tx_shift[DATA_WIDTH-1];
                            r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
                        end
                        if (w_sample) begin
                            r_data_shift <= w_data_next;
                            r_bit_cnt    <= r_bit_cnt + c_CNT_ONE;
                            if (r_bit_cnt == c_FRAME_LAST) begin
                                r_state <= ST_DONE;
                                r_miso  <= 1'b0;
                                if (r_addr_shift[ADDRESS_WIDTH-1]) begin
                                    r_wr_valid   <= 1'b1;
                                    r_wr_address <= {1'b0, r_addr_shift[ADDRESS_WIDTH-2:0]};
                                    r_wr_data    <= w_data_next;
                                end
                            end
                        end
                    end
                end

                ST_DONE: begin
                    r_miso <= 1'b0;
                    if (w_ss_rise) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_miso  <= 1'b0;
                end
            endcase
        end
    end

    assign MISO        = r_miso;
    assign wr_valid    = r_wr_valid;
    assign wr_address  = r_wr_address;
    assign wr_data     = r_wr_data;
    assign rd_req      = r_rd_req;
    assign rd_address  = r_rd_address;
    assign busy        = r_busy;
    assign frame_error = r_frame_error;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave
// Description : Directed self-checking bench for spi_slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave;

    localparam int c_HALF = 8;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        clock_polarity = 1'b0;
    logic        clock_phase = 1'b0;
    logic        SCK = 1'b0;
    logic        SS = 1'b1;
    logic        MOSI = 1'b0;
    logic        MISO;
    logic        wr_valid;
    logic [31:0] wr_address;
    logic [31:0] wr_data;
    logic        rd_req;
    logic [31:0] rd_address;
    logic [31:0] rd_data = 32'h0;
    logic        busy;
    logic        frame_error;

    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          fe_cnt = 0;
    logic [31:0] wr_addr_cap = '0;
    logic [31:0] wr_data_cap = '0;
    logic [31:0] rd_addr_cap = '0;

    spi_slave #(
        .DATA_WIDTH    (32),
        .ADDRESS_WIDTH (32),
        .SYNC_STAGES   (2)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .clock_polarity (clock_polarity),
        .clock_phase    (clock_phase),
        .SCK            (SCK),
        .SS             (SS),
        .MOSI           (MOSI),
        .MISO           (MISO),
        .wr_valid       (wr_valid),
        .wr_address     (wr_address),
        .wr_data        (wr_data),
        .rd_req         (rd_req),
        .rd_address     (rd_address),
        .rd_data        (rd_data),
        .busy           (busy),
        .frame_error    (frame_error)
    );

    always #5 clock = ~clock;

    // Pulse counters see every cycle an output is high, so a stretched pulse counts twice.
    always @(negedge clock) begin
        if (wr_valid) begin
            wr_cnt      = wr_cnt + 1;
            wr_addr_cap = wr_address;
            wr_data_cap = wr_data;
        end
        if (rd_req) begin
            rd_cnt      = rd_cnt + 1;
            rd_addr_cap = rd_address;
        end
        if (frame_error) fe_cnt = fe_cnt + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic spi_xfer(input bit cpol, input bit cpha, input logic [63:0] tx,
                            input int nbits, input int extra, input bit keep_ss,
                            output logic [63:0] rx);
        rx             = '0;
        clock_polarity = cpol;
        clock_phase    = cpha;
        SCK            = cpol;
        wait_clk(8);
        SS = 1'b0;
        if (!cpha) MOSI = tx[63];
        wait_clk(c_HALF);
        for (int i = 0; i < nbits; i++) begin
            SCK = ~cpol;
            if (cpha) MOSI = tx[63-i];
            else      rx[63-i] = MISO;
            wait_clk(c_HALF);
            SCK = cpol;
            if (cpha)        rx[63-i] = MISO;
            else if (i < 63) MOSI = tx[62-i];
            wait_clk(c_HALF);
        end
        for (int i = 0; i < extra; i++) begin
            SCK = ~cpol;
            wait_clk(c_HALF);
            SCK = cpol;
            wait_clk(c_HALF);
        end
        if (!keep_ss) begin
            SS = 1'b1;
            wait_clk(16);
        end
    endtask

    task automatic test_reset;
        wait_clk(4);
        checks++;
        if ({MISO, wr_valid, rd_req, busy, frame_error} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 00000", {MISO, wr_valid, rd_req, busy, frame_error});
        end
        checks++;
        if ({wr_address, wr_data, rd_address} !== 96'h0) begin
            errors++;
            $display("FAIL reset_buses got %h want 0", {wr_address, wr_data, rd_address});
        end
        reset_n = 1'b1;
        wait_clk(10);
    endtask

    task automatic test_write(input string name, input bit cpol, input bit cpha,
                              input logic [31:0] addr, input logic [31:0] data, input int extra);
        logic [63:0] rx;
        int          wr0, rd0, fe0;
        wr0 = wr_cnt; rd0 = rd_cnt; fe0 = fe_cnt;
        spi_xfer(cpol, cpha, {addr, data}, 64, extra, 1'b0, rx);
        checks++;
        if (wr_cnt - wr0 !== 1) begin
            errors++;
            $display("FAIL %s wr_pulses got %0d want 1", name, wr_cnt - wr0);
        end
        checks++;
        if (wr_addr_cap !== {1'b0, addr[30:0]}) begin
            errors++;
            $display("FAIL %s wr_address got %h want %h", name, wr_addr_cap, {1'b0, addr[30:0]});
        end
        checks++;
        if (wr_data_cap !== data) begin
            errors++;
            $display("FAIL %s wr_data got %h want %h", name, wr_data_cap, data);
        end
        checks++;
        if (rx !== 64'h0) begin
            errors++;
            $display("FAIL %s miso got %h want 0", name, rx);
        end
        checks++;
        if ((rd_cnt - rd0) !== 0 || (fe_cnt - fe0) !== 0) begin
            errors++;
            $display("FAIL %s stray_pulses got rd=%0d fe=%0d want 0 0", name, rd_cnt - rd0, fe_cnt - fe0);
        end
    endtask

    task automatic test_read(input string name, input bit cpol, input bit cpha,
                             input logic [31:0] addr, input logic [31:0] data);
        logic [63:0] rx;
        int          wr0, rd0;
        wr0 = wr_cnt; rd0 = rd_cnt;
        rd_data = data;
        spi_xfer(cpol, cpha, {addr, 32'hFFFF_0000}, 64, 0, 1'b0, rx);
        checks++;
        if (rd_cnt - rd0 !== 1) begin
            errors++;
            $display("FAIL %s rd_pulses got %0d want 1", name, rd_cnt - rd0);
        end
        checks++;
        if (rd_addr_cap !== addr) begin
            errors++;
            $display("FAIL %s rd_address got %h want %h", name, rd_addr_cap, addr);
        end
        checks++;
        if (rx[31:0] !== data) begin
            errors++;
            $display("FAIL %s miso_data got %h want %h", name, rx[31:0], data);
        end
        checks++;
        if (rx[63:32] !== 32'h0) begin
            errors++;
            $display("FAIL %s miso_addr_phase got %h want 0", name, rx[63:32]);
        end
        checks++;
        if (wr_cnt - wr0 !== 0) begin
            errors++;
            $display("FAIL %s wr_pulses got %0d want 0", name, wr_cnt - wr0);
        end
    endtask

    task automatic test_abort;
        logic [63:0] rx;
        int          wr0, rd0, fe0;
        wr0 = wr_cnt; rd0 = rd_cnt; fe0 = fe_cnt;
        spi_xfer(1'b0, 1'b0, {32'h8000_0030, 32'h1111_2222}, 10, 0, 1'b0, rx);
        checks++;
        if (fe_cnt - fe0 !== 1) begin
            errors++;
            $display("FAIL abort frame_error got %0d want 1", fe_cnt - fe0);
        end
        checks++;
        if ((wr_cnt - wr0) !== 0 || (rd_cnt - rd0) !== 0) begin
            errors++;
            $display("FAIL abort pulses got wr=%0d rd=%0d want 0 0", wr_cnt - wr0, rd_cnt - rd0);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort busy got %b want 0", busy);
        end
        test_write("after_abort", 1'b0, 1'b0, 32'h8000_0044, 32'h0BAD_BEEF, 0);
    endtask

    task automatic test_reset_mid;
        logic [63:0] rx;
        int          wr0, fe0;
        wr0 = wr_cnt; fe0 = fe_cnt;
        spi_xfer(1'b0, 1'b0, {32'h8000_0050, 32'hDEAD_BEEF}, 40, 0, 1'b1, rx);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset busy_before got %b want 1", busy);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({MISO, wr_valid, rd_req, busy, frame_error} !== 5'b0) begin
            errors++;
            $display("FAIL mid_reset ctrl got %b want 00000", {MISO, wr_valid, rd_req, busy, frame_error});
        end
        checks++;
        if ({wr_address, wr_data} !== 64'h0) begin
            errors++;
            $display("FAIL mid_reset buses got %h want 0", {wr_address, wr_data});
        end
        wait_clk(3);
        SS  = 1'b1;
        SCK = clock_polarity;
        wait_clk(4);
        reset_n = 1'b1;
        wait_clk(12);
        checks++;
        if ((fe_cnt - fe0) !== 0 || (wr_cnt - wr0) !== 0) begin
            errors++;
            $display("FAIL mid_reset pulses got fe=%0d wr=%0d want 0 0", fe_cnt - fe0, wr_cnt - wr0);
        end
        test_write("after_reset", 1'b0, 1'b0, 32'h8000_0060, 32'hC001_D00D, 0);
    endtask

    initial begin
        test_reset;
        test_write("mode0_write", 1'b0, 1'b0, 32'h8000_0010, 32'hA5A5_A5A5, 0);
        test_read("mode0_read", 1'b0, 1'b0, 32'h0000_0020, 32'h5A5A_1234);
        test_write("mode3_write", 1'b1, 1'b1, 32'h8000_0004, 32'h1234_5678, 0);
        test_read("mode3_read", 1'b1, 1'b1, 32'h0000_0004, 32'hCAFE_F00D);
        test_abort;
        test_reset_mid;
        test_write("mode1_extra", 1'b0, 1'b1, 32'h8000_0008, 32'h1357_9BDF, 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
